// File: rtl/mux_2to1_rr_pkg.sv
// Shared constants for the two-input round-robin stream multiplexer.
// Holds the channel identifiers and the output-stage FSM state encoding.
package mux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux_2to1_rr_arb.sv
// Two-requester round-robin arbiter, purely combinational.
// ptr names the channel that wins when both request at once.
module rr_arb2
  import mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = CH0;
    case (req)
      2'b01:   gnt_idx = CH0;
      2'b10:   gnt_idx = CH1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = CH0;
    endcase
  end

endmodule

// File: rtl/mux_2to1_rr.sv
// Two-to-one valid/ready stream mux with round-robin arbitration and a registered output.
// Optional per-channel saturating transfer counters are enabled with `define MUX_STATS_EN.
module mux_2to1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  out_state_t       state_reg;
  logic [WIDTH-1:0] data_reg;
  logic             sel_reg;
  logic             rr_ptr_reg;

  logic [WIDTH-1:0] in_data [2];
  logic [1:0]       req;
  logic [1:0]       ready_vec;
  logic             gnt_valid;
  logic             gnt_idx;
  logic             space;
  logic             take;

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign req        = {in1_valid, in0_valid};

  rr_arb2 u_arb (
    .req       (req),
    .ptr       (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A word may load in the same cycle the held one drains; nothing is acknowledged in reset.
  assign space = (state_reg == ST_EMPTY) | out_ready;
  assign take  = space & gnt_valid & ~rst;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = take & (gnt_idx == 1'(gi));
  end

  assign in0_ready = ready_vec[0];
  assign in1_ready = ready_vec[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      data_reg   <= '0;
      sel_reg    <= CH0;
      rr_ptr_reg <= CH0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (take) begin
            data_reg   <= in_data[gnt_idx];
            sel_reg    <= gnt_idx;
            rr_ptr_reg <= ~gnt_idx;
            state_reg  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (take) begin
            data_reg   <= in_data[gnt_idx];
            sel_reg    <= gnt_idx;
            rr_ptr_reg <= ~gnt_idx;
          end else if (out_ready) begin
            // data_reg/sel_reg keep their stale contents
            state_reg <= ST_EMPTY;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

`ifdef MUX_STATS_EN
  logic [CNT_W-1:0] cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (ready_vec[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign cnt0 = cnt_reg[0];
  assign cnt1 = cnt_reg[1];
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
